data_mem_arbiter: RTL and testbench

//  Shares the single 64x8 data memory (2 read ports, 1 write port) between two requesters.

---
 rtl/data_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one 2-read/1-write data memory between the core
// load/store path (A) and the debug/loader port (B).
module data_mem_arbiter #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_raddr1,
    input  logic [AW-1:0] a_raddr2,
    input  logic [AW-1:0] a_waddr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_raddr1,
    input  logic [AW-1:0] b_raddr2,
    input  logic [AW-1:0] b_waddr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,

    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic          busy,

    output logic          mem_enable,
    output logic          mem_rwn,
    output logic [AW-1:0] mem_raddr1,
    output logic [AW-1:0] mem_raddr2,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata1,
    input  logic [DW-1:0] mem_rdata2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q;
    logic          last_q;      // 0: A was granted last, 1: B was granted last
    logic          owner_q;     // requester that owns the in-flight command
    logic          cmd_we_q;
    logic [AW-1:0] cmd_raddr1_q;
    logic [AW-1:0] cmd_raddr2_q;
    logic [AW-1:0] cmd_waddr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic          mem_enable_q;
    logic          mem_rwn_q;
    logic          busy_q;
    logic          a_gnt_q;
    logic          b_gnt_q;
    logic          a_rvalid_q;
    logic          b_rvalid_q;

    logic          req_any_d;
    logic          win_b_d;
    logic          win_we_d;
    logic [AW-1:0] win_raddr1_d;
    logic [AW-1:0] win_raddr2_d;
    logic [AW-1:0] win_waddr_d;
    logic [DW-1:0] win_wdata_d;

    // B wins when it is the only requester, or on a tie when A was granted last.
    always_comb begin
        req_any_d    = a_req | b_req;
        win_b_d      = b_req & (~a_req | ~last_q);
        win_we_d     = a_we;
        win_raddr1_d = a_raddr1;
        win_raddr2_d = a_raddr2;
        win_waddr_d  = a_waddr;
        win_wdata_d  = a_wdata;
        if (win_b_d) begin
            win_we_d     = b_we;
            win_raddr1_d = b_raddr1;
            win_raddr2_d = b_raddr2;
            win_waddr_d  = b_waddr;
            win_wdata_d  = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_raddr1_q <= '0;
            cmd_raddr2_q <= '0;
            cmd_waddr_q  <= '0;
            cmd_wdata_q  <= '0;
            mem_enable_q <= 1'b0;
            mem_rwn_q    <= 1'b0;
            busy_q       <= 1'b0;
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
        end else begin
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        state_q      <= ISSUE;
                        last_q       <= win_b_d;
                        owner_q      <= win_b_d;
                        cmd_we_q     <= win_we_d;
                        cmd_raddr1_q <= win_raddr1_d;
                        cmd_raddr2_q <= win_raddr2_d;
                        cmd_waddr_q  <= win_waddr_d;
                        cmd_wdata_q  <= win_wdata_d;
                        mem_enable_q <= 1'b1;
                        mem_rwn_q    <= ~win_we_d;
                        busy_q       <= 1'b1;
                        a_gnt_q      <= ~win_b_d;
                        b_gnt_q      <= win_b_d;
                    end
                end
                ISSUE: begin
                    // The memory samples its controls at this edge; drop enable
                    // so exactly one operation is performed per grant.
                    mem_enable_q <= 1'b0;
                    if (cmd_we_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= RESP;
                        a_rvalid_q <= ~owner_q;
                        b_rvalid_q <= owner_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    mem_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign a_gnt      = a_gnt_q;
    assign b_gnt      = b_gnt_q;
    assign a_rvalid   = a_rvalid_q;
    assign b_rvalid   = b_rvalid_q;
    assign busy       = busy_q;
    assign mem_enable = mem_enable_q;
    assign mem_rwn    = mem_rwn_q;
    assign mem_raddr1 = cmd_raddr1_q;
    assign mem_raddr2 = cmd_raddr2_q;
    assign mem_waddr  = cmd_waddr_q;
    assign mem_wdata  = cmd_wdata_q;

    // Read data is a pass-through of the registered memory outputs; it is only
    // meaningful while one of the rvalid strobes is high.
    assign rdata1 = mem_rdata1;
    assign rdata2 = mem_rdata2;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 64x8 memory
// (registered read outputs) attached to the memory-side ports.
module tb_data_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_raddr1, a_raddr2, a_waddr, b_raddr1, b_raddr2, b_waddr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
    logic [DW-1:0] rdata1, rdata2;
    logic          mem_enable, mem_rwn;
    logic [AW-1:0] mem_raddr1, mem_raddr2, mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata1 = '0;
    logic [DW-1:0] mem_rdata2 = '0;
    logic [DW-1:0] mem [2**AW];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_raddr1(a_raddr1), .a_raddr2(a_raddr2),
        .a_waddr(a_waddr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_raddr1(b_raddr1), .b_raddr2(b_raddr2),
        .b_waddr(b_waddr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata1(rdata1), .rdata2(rdata2), .busy(busy),
        .mem_enable(mem_enable), .mem_rwn(mem_rwn),
        .mem_raddr1(mem_raddr1), .mem_raddr2(mem_raddr2),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
    );

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_enable) begin
            if (!mem_rwn) mem[mem_waddr] <= mem_wdata;
            else begin
                mem_rdata1 <= mem[mem_raddr1];
                mem_rdata2 <= mem[mem_raddr2];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] s_addr [4];
    logic [DW-1:0] s_exp  [4];

    initial begin
        s_addr[0] = 6'd5; s_addr[1] = 6'd9; s_addr[2] = 6'd1; s_addr[3] = 6'd2;
        s_exp[0]  = 8'hA5; s_exp[1] = 8'h3C; s_exp[2] = 8'h11; s_exp[3] = 8'h22;

        rst = 1'b0;
        a_req = 0; a_we = 0; a_raddr1 = 0; a_raddr2 = 0; a_waddr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_raddr1 = 0; b_raddr2 = 0; b_waddr = 0; b_wdata = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_men", mem_enable, 0);
        chk("rst_rwn", mem_rwn, 0);
        chk("rst_agnt", a_gnt, 0);
        chk("rst_waddr", mem_waddr, 0);
        rst = 1'b1;

        // 1: A write 0xA5 to address 5
        a_req = 1; a_we = 1; a_waddr = 6'd5; a_wdata = 8'hA5;
        tick();
        chk("t1_agnt", a_gnt, 1);
        chk("t1_bgnt", b_gnt, 0);
        chk("t1_men", mem_enable, 1);
        chk("t1_rwn", mem_rwn, 0);
        chk("t1_waddr", mem_waddr, 5);
        chk("t1_wdata", mem_wdata, 8'hA5);
        chk("t1_busy", busy, 1);
        a_req = 0;
        tick();
        chk("t1_men_off", mem_enable, 0);
        chk("t1_gnt_off", a_gnt, 0);
        chk("t1_idle", busy, 0);
        chk("t1_waddr_hold", mem_waddr, 5);

        // 2: A dual read of 5 and 0
        a_req = 1; a_we = 0; a_raddr1 = 6'd5; a_raddr2 = 6'd0;
        tick();
        chk("t2_agnt", a_gnt, 1);
        chk("t2_men", mem_enable, 1);
        chk("t2_rwn", mem_rwn, 1);
        chk("t2_raddr1", mem_raddr1, 5);
        a_req = 0;
        tick();
        chk("t2_rvalid", a_rvalid, 1);
        chk("t2_brvalid", b_rvalid, 0);
        chk("t2_rdata1", rdata1, 8'hA5);
        chk("t2_rdata2", rdata2, 8'h00);
        chk("t2_men_off", mem_enable, 0);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_rvalid_off", a_rvalid, 0);
        chk("t2_idle", busy, 0);

        // 3: continuous contention from reset alternates A,B,A,B
        rst = 1'b0;
        #1;
        chk("t3_rst_busy", busy, 0);
        a_req = 1; a_we = 1; a_waddr = 6'd1; a_wdata = 8'h11;
        b_req = 1; b_we = 1; b_waddr = 6'd2; b_wdata = 8'h22;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3_agnt%0d", i), a_gnt, (i % 4 == 0) ? 1 : 0);
            chk($sformatf("t3_bgnt%0d", i), b_gnt, (i % 4 == 2) ? 1 : 0);
            if (i % 2 == 0)
                chk($sformatf("t3_waddr%0d", i), mem_waddr, (i % 4 == 0) ? 1 : 2);
        end
        a_req = 0; b_req = 0;

        // 4: B read queued behind A's write to the same address
        a_req = 1; a_we = 1; a_waddr = 6'd9; a_wdata = 8'h3C;
        tick();
        chk("t4_agnt", a_gnt, 1);
        chk("t4_men", mem_enable, 1);
        a_req = 0;
        b_req = 1; b_we = 0; b_raddr1 = 6'd9; b_raddr2 = 6'd5;
        tick();
        chk("t4_bwait", b_gnt, 0);
        chk("t4_idle", busy, 0);
        tick();
        chk("t4_bgnt", b_gnt, 1);
        chk("t4_raddr1", mem_raddr1, 9);
        b_req = 0;
        tick();
        chk("t4_brvalid", b_rvalid, 1);
        chk("t4_arvalid", a_rvalid, 0);
        chk("t4_rdata1", rdata1, 8'h3C);
        chk("t4_rdata2", rdata2, 8'hA5);
        tick();
        chk("t4_brvalid_off", b_rvalid, 0);

        // 5: reset during ISSUE of a read
        a_req = 1; a_we = 0; a_raddr1 = 6'd9; a_raddr2 = 6'd1;
        tick();
        chk("t5_agnt", a_gnt, 1);
        chk("t5_men", mem_enable, 1);
        a_req = 0;
        #2 rst = 1'b0;
        #1;
        chk("t5_men_async", mem_enable, 0);
        chk("t5_busy", busy, 0);
        chk("t5_agnt_off", a_gnt, 0);
        tick();
        chk("t5_no_rvalid", a_rvalid, 0);
        rst = 1'b1;
        a_req = 1; a_we = 1; a_waddr = 6'd3; a_wdata = 8'h33;
        b_req = 1; b_we = 1; b_waddr = 6'd4; b_wdata = 8'h44;
        tick();
        chk("t5_next_agnt", a_gnt, 1);
        chk("t5_next_bgnt", b_gnt, 0);
        a_req = 0; b_req = 0;
        tick();

        // 6: A streams four reads at a 3-cycle cadence
        a_req = 1; a_we = 0; a_raddr1 = s_addr[0]; a_raddr2 = 6'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_gnt%0d", k), a_gnt, 1);
            chk($sformatf("t6_bgnt%0d", k), b_gnt, 0);
            if (k < 3) a_raddr1 = s_addr[k+1];
            else a_req = 0;
            tick();
            chk($sformatf("t6_rvalid%0d", k), a_rvalid, 1);
            chk($sformatf("t6_rdata1_%0d", k), rdata1, s_exp[k]);
            chk($sformatf("t6_rdata2_%0d", k), rdata2, 8'h33);
            chk($sformatf("t6_brvalid%0d", k), b_rvalid, 0);
            tick();
            chk($sformatf("t6_idle%0d", k), busy, 0);
            chk($sformatf("t6_rvalid_off%0d", k), a_rvalid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
